// File: rtl/tile_row_fetcher.sv
// Tile store read initiator: fetches one span of tile words on a scanline and
// serialises each 16-bit word into four 4bpp pixels on a valid/ready stream.
module tile_row_fetcher #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_draw,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  line_y,
  input  logic [4:0]  first_tile,
  input  logic [5:0]  num_tiles,
  output logic [13:0] tile_addr,
  input  logic [15:0] tile_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [3:0]  pix_data,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  if (FIFO_DEPTH != 2) begin : g_depth_chk
    $error("tile_row_fetcher: FIFO_DEPTH must be 2");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t      state, state_nxt;
  logic [6:0]  iss_left;
  logic [6:0]  emit_left;
  logic        vld_p0, vld_p1;
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  cnt;
  logic [1:0]  nib;
  logic [2:0]  occ;
  logic        launch, issue, push, accept, pop;
  logic [15:0] head;

  // Words buffered plus reads still travelling through the store pipeline.
  assign occ    = {1'b0, cnt} + {2'b00, vld_p0} + {2'b00, vld_p1};
  assign launch = (state == IDLE) && start && (num_tiles != 6'd0);
  assign issue  = (state == FETCH) && (iss_left != 7'd0) && (occ < 3'd2);
  assign push   = vld_p1;
  assign accept = pix_valid && pix_ready;
  assign pop    = accept && (nib == 2'd3);

  assign head      = fifo_mem[rd_ptr];
  assign pix_valid = (cnt != 2'd0);
  assign pix_last  = pix_valid && (nib == 2'd3) && (emit_left == 7'd1);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_comb begin
    case (nib)
      2'd0:    pix_data = head[15:12];
      2'd1:    pix_data = head[11:8];
      2'd2:    pix_data = head[7:4];
      default: pix_data = head[3:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_tiles == 6'd0) ? FIN : FETCH;
      FETCH:   if (issue && (iss_left == 7'd1)) state_nxt = DRAIN;
      DRAIN:   if (accept && pix_last) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: address on the store bus; p1: store data valid, pushed at end of cycle
  always_ff @(posedge clk_draw) begin
    if (rst) begin
      state     <= IDLE;
      tile_addr <= 14'd0;
      iss_left  <= 7'd0;
      emit_left <= 7'd0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
      nib       <= 2'd0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= launch || issue;
      vld_p1 <= vld_p0;
      // {tile_x, tile_col} counts as one 6-bit value so tile_x wraps mod 32.
      if (launch) begin
        tile_addr <= {line_y, first_tile, 1'b0};
        iss_left  <= {num_tiles, 1'b0} - 7'd1;
      end else if (issue) begin
        tile_addr <= {tile_addr[13:6], tile_addr[5:0] + 6'd1};
        iss_left  <= iss_left - 7'd1;
      end
      if ((state == IDLE) && start) emit_left <= {num_tiles, 1'b0};
      else if (pop)                 emit_left <= emit_left - 7'd1;
      if (push)   wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      if (accept) nib    <= nib + 2'd1;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_draw) begin
    if (push) fifo_mem[wr_ptr] <= tile_data;
  end

endmodule
